// File: rtl/nukv_resp_pack.sv
// nukv_resp_pack: packs a 64-bit word stream into LANES-wide lines with a one-entry output register.
// Optional NUKV_RESP_PACK_TIMEOUT_EN flushes a partial line after TIMEOUT_CYCLES idle cycles.
module nukv_resp_pack #(
    parameter int META_WIDTH = 64,
    parameter int LANES = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [META_WIDTH+63:0]  input_data,
    input  logic                    input_valid,
    input  logic                    input_last,
    output logic                    input_ready,
    output logic [LANES*64-1:0]     output_data,
    output logic [META_WIDTH-1:0]   output_meta,
    output logic [3:0]              output_words,
    output logic                    output_valid,
    output logic                    output_last,
    input  logic                    output_ready,
    output logic [31:0]             lines_sent
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam logic [3:0] LAST_IDX = 4'(LANES - 1);
    typedef enum logic {ST_EMPTY, ST_FILL} state_t;
    state_t state;
    logic [3:0] idx;
    logic [LW-1:0] lane;
    logic [LANES-1:0][63:0] acc, line;
    logic [META_WIDTH-1:0] meta, in_meta;
    logic [63:0] word;
    logic accept, close, flush;
    assign word = input_data[63:0];
    assign in_meta = input_data[META_WIDTH+63:64];
    assign lane = idx[LW-1:0];
    assign input_ready = !output_valid || output_ready;
    assign accept = input_valid && input_ready;
    assign close = accept && (idx == LAST_IDX || input_last);
    always_comb begin
        line = acc;
        line[lane] = word;
    end
`ifdef NUKV_RESP_PACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;
    // an accepted word always wins over a flush in the same cycle
    assign flush = state == ST_FILL && !accept && input_ready && tcnt == TMAX;
`else
    assign flush = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            idx <= '0;
            acc <= '0;
            meta <= '0;
            output_data <= '0;
            output_meta <= '0;
            output_words <= '0;
            output_valid <= 1'b0;
            output_last <= 1'b0;
            lines_sent <= '0;
`ifdef NUKV_RESP_PACK_TIMEOUT_EN
            tcnt <= '0;
`endif
        end else begin
            if (output_valid && output_ready) begin
                output_valid <= 1'b0;
                lines_sent <= lines_sent + 32'd1;
            end
            if (close || flush) begin
                output_data <= close ? line : acc;
                output_meta <= state == ST_EMPTY ? in_meta : meta;
                output_words <= close ? idx + 4'd1 : idx;
                output_last <= close && input_last;
                output_valid <= 1'b1;
                acc <= '0;
                idx <= '0;
                state <= ST_EMPTY;
            end else if (accept) begin
                acc[lane] <= word;
                if (state == ST_EMPTY) meta <= in_meta;
                idx <= idx + 4'd1;
                state <= ST_FILL;
            end
`ifdef NUKV_RESP_PACK_TIMEOUT_EN
            tcnt <= (accept || flush || state == ST_EMPTY) ? '0 : (tcnt == TMAX ? tcnt : tcnt + 1'b1);
`endif
        end
    end
endmodule
